phy_rx_link_ctrl: RTL
=====================

# phy_rx_link_ctrl

Link-training and lane-supervision controller for the two-lane PHY receiver. It sits after the per-lane serial-to-parallel converters and before byte unstriping. It decides when the link is up from comma (0xBC) runs on both lanes, forwards data bytes only while the link is up, and drops back to resync on lane timeout or lane misalignment. All logic runs on the byte clock, and every output is registered.

## Interface
Parameters:
- COMMA, 8'hBC, idle/comma symbol sent by the transmitter when it has no data
- SYNC_COUNT, 4, consecutive commas a lane needs to lock
- TIMEOUT, 8, cycles without a lane strobe tolerated while ACTIVE
- MISALIGN_MAX, 2, consecutive misaligned strobe cycles tolerated while ACTIVE

Ports:
- clk  in  1  byte clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  training enable; low forces IDLE
- data_in_lane0  in  8  parallel byte, lane 0
- valid_in_lane0  in  1  one-cycle strobe, data_in_lane0 holds a new byte
- data_in_lane1  in  8  parallel byte, lane 1
- valid_in_lane1  in  1  one-cycle strobe, lane 1
- data_out_lane0  out  8  forwarded byte, lane 0
- data_out_lane1  out  8  forwarded byte, lane 1
- valid_out  out  1  both data_out lanes hold a data (non-comma) byte pair
- link_up  out  1  high in ACTIVE
- lane_lock  out  2  per-lane lock flags, bit0 = lane 0
- state  out  2  IDLE=00, SYNC=01, ACTIVE=10
- err_count  out  8  saturating count of ACTIVE→SYNC drops

## Operation
- Reset: state=IDLE, all counters 0, lane_lock=00, link_up=0, valid_out=0, data_out_lane0/1=8'h00, err_count=0.
- IDLE → SYNC when enable=1. Lock counters are cleared on entering SYNC.
- SYNC: each lane has its own comma counter, sized 0..SYNC_COUNT.
  - A strobe with byte==COMMA increments that lane's counter.
  - A strobe with byte!=COMMA clears that lane's counter to 0, and also clears its lock if the lane is not yet locked.
  - A cycle with no strobe leaves the counter unchanged.
  - Reaching SYNC_COUNT sets lane_lock[n]. The lock then stays set until the block leaves SYNC.
- SYNC → ACTIVE in the cycle after lane_lock becomes 11.
- ACTIVE: each lane has a timeout counter.
  - The counter clears on that lane's strobe and increments otherwise.
  - If either counter reaches TIMEOUT, the block goes to SYNC.
- ACTIVE, both strobes in the same cycle:
  - Both bytes non-comma: register the bytes to data_out and assert valid_out for 1 cycle.
  - Both bytes comma: idle; valid_out=0 and data_out holds its value.
  - Exactly one byte is comma: misaligned cycle.
- ACTIVE, exactly one strobe in a cycle: misaligned cycle.
- Misalignment handling:
  - Misaligned cycles increment the misalign counter.
  - Any aligned strobe cycle clears the counter.
  - Cycles with no strobe on either lane leave it unchanged.
  - Reaching MISALIGN_MAX sends the block to SYNC.
- Any ACTIVE→SYNC transition:
  - Increments err_count, saturating at 8'hFF.
  - Clears lane_lock, all counters and valid_out.
  - data_out holds its value.
- enable=0 in any state → IDLE next cycle. This does not count as an error.
- Reset mid-operation overrides everything, including an ACTIVE→SYNC transition in the same cycle. err_count returns to 0.

## Timing
- Input strobe to valid_out/data_out: 1 cycle (registered).
- SYNC_COUNT-th comma on the later lane → lane_lock visible next cycle → state=ACTIVE and link_up=1 one cycle after that.
- A data byte pair arriving in the same cycle the state becomes ACTIVE is forwarded. Strobes during SYNC are never forwarded.
- Timeout: drop to SYNC in the cycle after the counter reaches TIMEOUT, i.e. TIMEOUT+1 strobe-free cycles after the last strobe.
- The same-cycle priority order is reset > enable=0 > timeout > misalign > normal ACTIVE.
- valid_out is never high outside ACTIVE.

## Test plan
- Reset, enable=1, 4 aligned comma pairs → lane_lock=11 after 4th strobe+1, state=10 and link_up=1 one cycle later, err_count=0.
- ACTIVE, strobes with lane0=8'h12 / lane1=8'h34 → next cycle data_out_lane0=8'h12, data_out_lane1=8'h34, valid_out=1 for one cycle; a comma pair gives valid_out=0.
- Lane 1 sends 3 commas, then 8'h55, then 4 commas; lane 0 sends 8 commas → lane_lock[1] sets only after the last 4 commas; ACTIVE follows.
- ACTIVE, lane 1 strobes stop while lane 0 continues → misaligned cycles return the block to SYNC after 2 cycles, err_count=1, valid_out=0, link_up=0.
- ACTIVE, both lanes silent 9 cycles → SYNC via timeout, err_count increments. 256 forced drops → err_count saturates at 8'hFF.
- enable=0 during ACTIVE → IDLE next cycle, err_count unchanged. Reset asserted during SYNC → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/phy_rx_link_ctrl.sv
// Two-lane PHY receive link controller: trains on comma runs, forwards data byte
// pairs while the link is up, and falls back to resync on lane timeout or skew.
module phy_rx_link_ctrl #(
    parameter logic [7:0] COMMA        = 8'hBC,
    parameter int         SYNC_COUNT   = 4,
    parameter int         TIMEOUT      = 8,
    parameter int         MISALIGN_MAX = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in_lane0,
    input  logic       valid_in_lane0,
    input  logic [7:0] data_in_lane1,
    input  logic       valid_in_lane1,
    output logic [7:0] data_out_lane0,
    output logic [7:0] data_out_lane1,
    output logic       valid_out,
    output logic       link_up,
    output logic [1:0] lane_lock,
    output logic [1:0] state,
    output logic [7:0] err_count
);

    localparam int SW = $clog2(SYNC_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = $clog2(MISALIGN_MAX + 1);
    localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_COUNT);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [MW-1:0] MIS_MAX  = MW'(MISALIGN_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SYNC   = 2'b01,
        ACTIVE = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   drop;

    logic [1:0]          strobe, comma;
    logic [1:0][SW-1:0]  sync_cnt, sync_nxt;
    logic [1:0][TW-1:0]  to_cnt, to_nxt;
    logic [MW-1:0]       mis_cnt, mis_nxt;
    logic                data_pair, aligned, misaligned, timeout_hit, mis_hit;

    assign strobe = {valid_in_lane1, valid_in_lane0};
    assign comma  = {data_in_lane1 == COMMA, data_in_lane0 == COMMA};
    assign state  = state_q;

    always_comb begin
        data_pair  = (&strobe) && (comma == 2'b00);
        aligned    = (&strobe) && (comma == 2'b00 || comma == 2'b11);
        misaligned = (|strobe) && !aligned;
        for (int n = 0; n < 2; n++) begin
            sync_nxt[n] = sync_cnt[n];
            if (strobe[n]) begin
                if (!comma[n])
                    sync_nxt[n] = '0;
                else if (sync_cnt[n] != SYNC_MAX)
                    sync_nxt[n] = sync_cnt[n] + 1'b1;
            end
            to_nxt[n] = to_cnt[n];
            if (strobe[n])
                to_nxt[n] = '0;
            else if (to_cnt[n] != TO_MAX)
                to_nxt[n] = to_cnt[n] + 1'b1;
        end
        mis_nxt = mis_cnt;
        if (misaligned)
            mis_nxt = mis_cnt + 1'b1;
        else if (aligned)
            mis_nxt = '0;
        // Timeout acts on the registered count (one cycle late); skew acts on the new count.
        timeout_hit = (to_cnt[0] == TO_MAX) || (to_cnt[1] == TO_MAX);
        mis_hit     = (mis_nxt >= MIS_MAX);
    end

    always_comb begin
        state_d = state_q;
        drop    = 1'b0;
        case (state_q)
            IDLE:    if (enable) state_d = SYNC;
            SYNC: begin
                if (!enable)                 state_d = IDLE;
                else if (lane_lock == 2'b11) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (timeout_hit || mis_hit) begin
                    state_d = SYNC;
                    drop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_cnt       <= '0;
            to_cnt         <= '0;
            mis_cnt        <= '0;
            lane_lock      <= 2'b00;
            link_up        <= 1'b0;
            valid_out      <= 1'b0;
            data_out_lane0 <= 8'h00;
            data_out_lane1 <= 8'h00;
            err_count      <= 8'h00;
        end else begin
            valid_out <= 1'b0;
            link_up   <= (state_d == ACTIVE);
            if (state_q == ACTIVE && state_d == ACTIVE) begin
                to_cnt  <= to_nxt;
                mis_cnt <= mis_nxt;
                if (data_pair) begin
                    data_out_lane0 <= data_in_lane0;
                    data_out_lane1 <= data_in_lane1;
                    valid_out      <= 1'b1;
                end
            end else if (state_q == SYNC && state_d != IDLE) begin
                sync_cnt <= sync_nxt;
                to_cnt   <= '0;
                mis_cnt  <= '0;
                for (int n = 0; n < 2; n++)
                    lane_lock[n] <= lane_lock[n] | (sync_nxt[n] == SYNC_MAX);
            end else begin
                // Entering SYNC, dropping out of ACTIVE, or idling: start training afresh.
                sync_cnt  <= '0;
                to_cnt    <= '0;
                mis_cnt   <= '0;
                lane_lock <= 2'b00;
            end
            if (drop && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
